vram_responder: RTL
===================

Name: vram_responder

Overview:
- Memory-side responder for the tile/palette fetch interface of the video pipeline.
- Owns the tile RAM and palette RAM. It answers the video block's 16-bit RAM address requests with tile code (8 bits) and palette index (6 bits) every clock.
- Arbitrates CPU read/write accesses into the same RAMs through a req/ack handshake. CPU accesses are granted during blanking, or are forced after a starvation limit.

Parameters:
- TILE_BASE, 16'h4000, CPU/video base address of tile RAM.
- TILE_DEPTH, 1024, tile RAM entries (8 bits each).
- PAL_BASE, 16'h4400, base address of palette RAM.
- PAL_DEPTH, 1024, palette RAM entries (6 bits each).
- STARVE_LIMIT, 1024, max cycles a pending CPU request waits before a forced grant.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low
- tile_RAM_addr  in  16  video tile fetch address
- tile_ROM_addr  out  8  tile code returned to video
- palette_RAM_addr  in  16  video palette fetch address
- palette_ROM_addr  out  6  palette index returned to video
- blank  in  1  high during h/v blanking
- cpu_req  in  1  CPU access request, level, held until ack
- cpu_we  in  1  1 = write, 0 = read; sampled with request
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid with cpu_ack
- cpu_err  out  1  pulses with cpu_ack when the address maps to neither RAM

Behaviour:
- Reset (rst low, async): tile_ROM_addr=0, palette_ROM_addr=0, cpu_ack=0, cpu_rdata=0, cpu_err=0, FSM=IDLE, starve counter=0. RAM contents are not cleared.
- Decode: an address is in a bank when it lies in [BASE, BASE+DEPTH). The bank index is addr-BASE, truncated to clog2(DEPTH) bits.
- Video path, fixed latency 1:
  - Outputs register bank[addr] on every clk edge.
  - An out-of-range tile address returns 8'h00; an out-of-range palette address returns 6'h00.
  - The video path never stalls.
- CPU FSM states IDLE, WAIT, ACCESS, DONE:
  - IDLE: cpu_req=1 latches cpu_we/cpu_addr/cpu_wdata and moves to WAIT.
  - WAIT: blank=1 moves to ACCESS. Otherwise the starve counter increments; when counter==STARVE_LIMIT-1, move to ACCESS (forced grant).
  - ACCESS (exactly one cycle):
    - Write: updates the decoded bank. Palette stores wdata[5:0].
    - Read: captures bank data; palette data is zero-extended to 8 bits.
    - Out-of-range read returns 8'hFF; out-of-range write is discarded.
  - ACCESS to DONE: cpu_ack=1 for exactly one cycle on DONE entry, with cpu_rdata/cpu_err valid that cycle. cpu_rdata holds until the next ack.
  - DONE: stays until cpu_req=0, then returns to IDLE with the starve counter cleared. This prevents a held req from double-issuing.
- Minimum transaction: req high at cycle 0 and blank high gives ack at cycle 3 (IDLE, WAIT, ACCESS, ack).
- Same-address collision in an ACCESS write cycle: the video read returns the old data (read-before-write). The new data is visible the next cycle.
- Forced grant during active video: the video output is unaffected (dual-port banks). The only visible effect is the collision rule above.
- cpu_req dropped while in WAIT: the request is abandoned, FSM returns to IDLE, no ack.
- Latched fields are immune to input changes after IDLE.
- Counter width is clog2(STARVE_LIMIT)+1. It does not wrap; it saturates at the grant.

Decomposition:
- vram_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} vram_state_t
  - default base/depth constants
  - the out-of-range read value constant 8'hFF
- Sub-module vram_bank (parameters WIDTH, DEPTH): one synchronous read port (video) and one read/write port (CPU). It implements the read-before-write collision rule, is instantiated twice, and maps to inferred block RAM.

Test Plan:
- Write/readback:
  - Stimulus: blank=1; CPU writes 8'hA5 to 16'h4010, then reads 16'h4010.
  - Response: each ack arrives at cycle 3 after req, cpu_err=0, read cpu_rdata=8'hA5.
  - Then drive tile_RAM_addr=16'h4010; tile_ROM_addr=8'hA5 one cycle later.
- Palette truncation: write 8'hFF to 16'h4402, then read it back → cpu_rdata=8'h3F, and palette_ROM_addr=6'h3F for address 16'h4402.
- Starvation:
  - Stimulus: blank held 0, STARVE_LIMIT=16, CPU write pending.
  - Response: ACCESS happens after exactly 16 WAIT cycles, ack in the following cycle. The video outputs keep updating every cycle throughout.
- Collision: video address equals the CPU write address in the ACCESS cycle → old value on the next-cycle output, new value one cycle later.
- Out of range:
  - CPU read of 16'h0000 → cpu_rdata=8'hFF, cpu_err=1 with ack.
  - CPU write of 16'h8000 → no bank changes.
  - Video address 16'h0000 → output 0.
- Handshake and reset:
  - Held cpu_req gives exactly one ack.
  - req dropped in WAIT gives no ack.
  - rst low mid-WAIT clears all outputs immediately (asynchronously); the FSM restarts in IDLE.

Source files
------------

// File: rtl/vram_pkg.sv
`default_nettype none
// vram_pkg: shared state encoding, default memory map and decode helper for vram_responder.

package vram_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} vram_state_t;

  localparam logic [15:0] TILE_BASE_DEF  = 16'h4000;
  localparam int          TILE_DEPTH_DEF = 1024;
  localparam logic [15:0] PAL_BASE_DEF   = 16'h4400;
  localparam int          PAL_DEPTH_DEF  = 1024;
  localparam int          STARVE_DEF     = 1024;
  localparam logic [7:0]  OOR_RDATA      = 8'hFF;

  // 17-bit compare so BASE+DEPTH may reach 16'hFFFF+1 without wrapping.
  function automatic logic in_bank(input logic [15:0] addr, input logic [15:0] base,
                                   input int depth);
    logic [16:0] a;
    logic [16:0] lo;
    logic [16:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + 17'(depth);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_bank.sv
`default_nettype none
// vram_bank: dual-port RAM, video read-only port plus CPU read/write port.
// Both reads are registered and return the pre-write contents on a same-address write.

module vram_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    vid_addr,
  output logic [WIDTH-1:0] vid_q,
  input  logic             cpu_en,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    vid_q <= mem[vid_addr];
    if (cpu_en) begin
      if (cpu_we) mem[cpu_addr] <= cpu_wdata;
      cpu_q <= mem[cpu_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/vram_responder.sv
`default_nettype none
// vram_responder: serves video tile/palette fetches every clock and arbitrates CPU
// accesses into the same RAMs, granted in blanking or forced after a starvation limit.

module vram_responder
  import vram_pkg::*;
#(
  parameter logic [15:0] TILE_BASE    = TILE_BASE_DEF,
  parameter int          TILE_DEPTH   = TILE_DEPTH_DEF,
  parameter logic [15:0] PAL_BASE     = PAL_BASE_DEF,
  parameter int          PAL_DEPTH    = PAL_DEPTH_DEF,
  parameter int          STARVE_LIMIT = STARVE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] tile_RAM_addr,
  output logic [7:0]  tile_ROM_addr,
  input  logic [15:0] palette_RAM_addr,
  output logic [5:0]  palette_ROM_addr,
  input  logic        blank,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err
);

  localparam int TAW = $clog2(TILE_DEPTH);
  localparam int PAW = $clog2(PAL_DEPTH);
  localparam int SW  = $clog2(STARVE_LIMIT) + 1;

  vram_state_t    state;
  logic [SW-1:0]  starve;
  logic           lat_we;
  logic [15:0]    lat_addr;
  logic [7:0]     lat_wdata;
  logic [7:0]     rd_hold;
  logic [7:0]     rd_mux;
  logic           tile_vhit;
  logic           pal_vhit;

  logic [7:0]     tile_vq;
  logic [7:0]     tile_cq;
  logic [5:0]     pal_vq;
  logic [5:0]     pal_cq;

  logic           lat_tile_hit;
  logic           lat_pal_hit;
  logic           in_access;

  assign lat_tile_hit = in_bank(lat_addr, TILE_BASE, TILE_DEPTH);
  assign lat_pal_hit  = in_bank(lat_addr, PAL_BASE, PAL_DEPTH) && !lat_tile_hit;
  assign in_access    = (state == ACCESS);

  vram_bank #(.WIDTH(8), .DEPTH(TILE_DEPTH)) u_tile (
    .clk       (clk),
    .vid_addr  (TAW'(tile_RAM_addr - TILE_BASE)),
    .vid_q     (tile_vq),
    .cpu_en    (in_access && lat_tile_hit),
    .cpu_we    (lat_we),
    .cpu_addr  (TAW'(lat_addr - TILE_BASE)),
    .cpu_wdata (lat_wdata),
    .cpu_q     (tile_cq)
  );

  vram_bank #(.WIDTH(6), .DEPTH(PAL_DEPTH)) u_pal (
    .clk       (clk),
    .vid_addr  (PAW'(palette_RAM_addr - PAL_BASE)),
    .vid_q     (pal_vq),
    .cpu_en    (in_access && lat_pal_hit),
    .cpu_we    (lat_we),
    .cpu_addr  (PAW'(lat_addr - PAL_BASE)),
    .cpu_wdata (lat_wdata[5:0]),
    .cpu_q     (pal_cq)
  );

  // RAM read registers carry no reset; registered hit flags give the reset and out-of-range zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_vhit <= 1'b0;
      pal_vhit  <= 1'b0;
    end else begin
      tile_vhit <= in_bank(tile_RAM_addr, TILE_BASE, TILE_DEPTH);
      pal_vhit  <= in_bank(palette_RAM_addr, PAL_BASE, PAL_DEPTH);
    end
  end

  assign tile_ROM_addr    = tile_vhit ? tile_vq : 8'h00;
  assign palette_ROM_addr = pal_vhit ? pal_vq : 6'h00;

  always_comb begin
    rd_mux = OOR_RDATA;
    if (lat_tile_hit)     rd_mux = tile_cq;
    else if (lat_pal_hit) rd_mux = {2'b00, pal_cq};
  end

  assign cpu_rdata = cpu_ack ? rd_mux : rd_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      starve    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      rd_hold   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      if (cpu_ack) rd_hold <= rd_mux;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            lat_we    <= cpu_we;
            lat_addr  <= cpu_addr;
            lat_wdata <= cpu_wdata;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!cpu_req) begin
            state  <= IDLE;
            starve <= '0;
          end else if (blank || starve == SW'(STARVE_LIMIT - 1)) begin
            state <= ACCESS;
          end else begin
            starve <= starve + 1'b1;
          end
        end
        ACCESS: begin
          state   <= DONE;
          cpu_ack <= 1'b1;
          cpu_err <= !(lat_tile_hit || lat_pal_hit);
        end
        DONE: begin
          if (!cpu_req) begin
            state  <= IDLE;
            starve <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
